// File: rtl/maxpool_stream.sv
`timescale 1ns/1ps
// maxpool_stream
// Streaming 1-D max pooling over fixed-length vectors of signed samples.
// Each vector of LEN samples is cut into windows of WIN samples (stride WIN).
// A short final window collects the LEN mod WIN tail samples, so each vector
// yields ceil(LEN/WIN) results. There is one output register with
// valid/ready handshaking. Back-pressure stalls only the sample that would
// close a window. Samples that do not close a window are always accepted.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   s_data_in    signed input sample
//   s_valid      input sample valid
//   s_ready      block accepts a sample this cycle
//   m_data_out   signed pooled result
//   m_valid      m_data_out holds a result
//   m_ready      downstream accepts the result
module maxpool_stream #(
    parameter int WIDTH = 8,
    parameter int WIN   = 2,
    parameter int LEN   = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] m_data_out,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int WC_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EC_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WIN - 1);
    localparam logic [EC_W-1:0] ELEM_LAST = EC_W'(LEN - 1);

    logic [WC_W-1:0]         win_cnt;
    logic [EC_W-1:0]         elem_cnt;
    logic signed [WIDTH-1:0] run_max;
    logic signed [WIDTH-1:0] pooled;
    logic                    win_first;
    logic                    vec_last;
    logic                    closing;
    logic                    in_xfer;
    logic                    out_xfer;

    always_comb begin
        win_first = (win_cnt == '0);
        vec_last  = (elem_cnt == ELEM_LAST);
        closing   = (win_cnt == WIN_LAST) || vec_last;
        // The first sample of a window replaces whatever run_max holds.
        // run_max can hold the result of the previous window or vector.
        pooled    = (win_first || (s_data_in > run_max)) ? s_data_in : run_max;
        // A closing sample needs the output register free, or being
        // emptied this cycle.
        s_ready   = !reset && !(m_valid && !m_ready && closing);
        in_xfer   = s_valid && s_ready;
        out_xfer  = m_valid && m_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt    <= '0;
            elem_cnt   <= '0;
            run_max    <= '0;
            m_data_out <= '0;
            m_valid    <= 1'b0;
        end else begin
            if (in_xfer) begin
                run_max  <= pooled;
                win_cnt  <= closing  ? '0 : win_cnt + WC_W'(1);
                elem_cnt <= vec_last ? '0 : elem_cnt + EC_W'(1);
            end
            // A load takes priority over the clear. This keeps back-to-back
            // results without a bubble.
            if (in_xfer && closing) begin
                m_data_out <= pooled;
                m_valid    <= 1'b1;
            end else if (out_xfer) begin
                m_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
`timescale 1ns/1ps
module tb_maxpool_stream;

    localparam int WIDTH = 8;
    localparam int WIN   = 2;
    localparam int LEN   = 7;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic signed [WIDTH-1:0] s_data_in = '0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic signed [WIDTH-1:0] m_data_out;
    logic                    m_valid;
    logic                    m_ready = 1'b0;

    maxpool_stream #(.WIDTH(WIDTH), .WIN(WIN), .LEN(LEN)) dut (
        .clk(clk), .reset(reset),
        .s_data_in(s_data_in), .s_valid(s_valid), .s_ready(s_ready),
        .m_data_out(m_data_out), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int sb[$];
    int win_buf[$];
    int pos = 0;
    bit use_model = 0;
    bit rand_ready = 0;

    task automatic check(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: group accepted samples by position in the vector.
    function automatic void model_accept(input int d);
        int m;
        win_buf.push_back(d);
        if (((pos + 1) % WIN == 0) || (pos == LEN - 1)) begin
            m = win_buf[0];
            foreach (win_buf[i]) if (win_buf[i] > m) m = win_buf[i];
            sb.push_back(m);
            win_buf.delete();
        end
        pos = (pos + 1) % LEN;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        s_valid = 1'b0;
        #1;
        check("reset_s_ready_comb", int'(s_ready), 0);
        sb.delete();
        win_buf.delete();
        pos = 0;
        @(negedge clk); #1;
        check("reset_m_valid", int'(m_valid), 0);
        check("reset_m_data", int'(m_data_out), 0);
        check("reset_s_ready", int'(s_ready), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input int d, output bit stalled);
        int t;
        stalled = 0;
        t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data_in = WIDTH'(d);
        #1;
        while (!s_ready) begin
            stalled = 1;
            t++;
            if (t > 1000) begin
                check("send_timeout", 1, 0);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk); #1;
        end
        if (use_model) model_accept(d);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold.
    bit prev_stall = 0;
    int prev_data = 0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                check("hold_valid", int'(m_valid), 1);
                check("hold_data", int'(m_data_out), prev_data);
            end
            if (m_valid && m_ready) begin
                cmp_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++;
                    $display("FAIL out_unexpected: got %0d expected none at %0t", m_data_out, $time);
                end else begin
                    int e;
                    e = sb.pop_front();
                    if (int'(m_data_out) != e) begin
                        err_cnt++;
                        $display("FAIL out_data: got %0d expected %0d at %0t", m_data_out, e, $time);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data = int'(m_data_out);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) m_ready = ($urandom_range(0, 2) != 0);
        end
    end

    int vec_a[7] = '{3, -5, 7, 2, 0, 0, 9};
    int vec_b[7] = '{-1, -2, 5, 5, -7, 100, -128};
    int vec_c[7] = '{1, 2, 3, 4, 5, 6, 7};

    initial begin
        bit st;
        int any_stall;

        // Basic vector, downstream always ready.
        do_reset();
        m_ready = 1'b1;
        sb.push_back(3); sb.push_back(7); sb.push_back(0); sb.push_back(9);
        any_stall = 0;
        foreach (vec_a[i]) begin
            send(vec_a[i], st);
            if (st) any_stall++;
        end
        idle();
        check("basic_s_ready_stalls", any_stall, 0);
        drain("basic_drain");

        // Signed comparison.
        do_reset();
        m_ready = 1'b1;
        sb.push_back(-3);
        send(-8, st);
        send(-3, st);
        idle();
        drain("signed_drain");

        // Back-pressure: 4 held, 6 accepted, closing 5 stalled.
        do_reset();
        m_ready = 1'b0;
        sb.push_back(4); sb.push_back(6);
        send(1, st);
        send(4, st);
        send(6, st);
        check("bp_six_stalled", int'(st), 0);
        @(negedge clk);
        s_data_in = 5;
        s_valid = 1'b1;
        #1;
        check("bp_five_s_ready", int'(s_ready), 0);
        repeat (3) @(negedge clk);
        #1;
        check("bp_held_valid", int'(m_valid), 1);
        check("bp_held_data", int'(m_data_out), 4);
        check("bp_still_blocked", int'(s_ready), 0);
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        check("bp_b2b_s_ready", int'(s_ready), 1);
        idle();
        drain("bp_drain");

        // Two vectors back-to-back: no merge across the boundary.
        do_reset();
        m_ready = 1'b1;
        sb.push_back(3); sb.push_back(7); sb.push_back(0); sb.push_back(9);
        sb.push_back(-1); sb.push_back(5); sb.push_back(100); sb.push_back(-128);
        foreach (vec_a[i]) send(vec_a[i], st);
        foreach (vec_b[i]) send(vec_b[i], st);
        idle();
        drain("two_vec_drain");

        // Reset mid-vector with a pending output, then a fresh vector.
        do_reset();
        m_ready = 1'b0;
        send(9, st);
        send(9, st);
        send(9, st);
        idle();
        do_reset();
        m_ready = 1'b1;
        sb.push_back(2); sb.push_back(4); sb.push_back(6); sb.push_back(7);
        foreach (vec_c[i]) send(vec_c[i], st);
        idle();
        drain("reset_mid_drain");

        // Randomized traffic against the reference model.
        do_reset();
        use_model = 1;
        rand_ready = 1;
        for (int v = 0; v < 1000; v++) begin
            for (int k = 0; k < LEN; k++) begin
                int d;
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                case ($urandom_range(0, 9))
                    0: d = -128;
                    1: d = 127;
                    default: d = int'($signed(WIDTH'($urandom)));
                endcase
                send(d, st);
            end
        end
        idle();
        rand_ready = 0;
        @(negedge clk);
        m_ready = 1'b1;
        drain("random_drain");
        check("random_model_pos", pos, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
